// File: rtl/rx_uart_pkg.sv
// Shared constants and state encoding for the UART receive line framing logic.
package rx_uart_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        CR_SEEN  = 2'd1,
        DRAIN    = 2'd2,
        OVERFLOW = 2'd3
    } line_state_e;

endpackage

// File: rtl/rx_line_controller_if.sv
// Byte-in / line-out bus between the UART RX byte source, the line controller and the command parser.
interface rx_line_controller_if #(
    parameter int LEN_W = 6
);
    // in_byte is a single-cycle strobe with no back-pressure. out_byte moves only on
    // out_byte_valid & out_byte_ready at the rising edge; once valid is raised, valid and
    // out_byte stay put until that transfer happens.
    logic [7:0]       in_byte;
    logic             in_byte_valid;
    logic [7:0]       out_byte;
    logic             out_byte_valid;
    logic             out_byte_ready;
    logic [LEN_W-1:0] line_len;
    logic             line_done;
    logic             overflow_err;
    logic             overrun_err;
    logic             busy;

    modport master (
        input  in_byte, in_byte_valid, out_byte_ready,
        output out_byte, out_byte_valid, line_len, line_done, overflow_err, overrun_err, busy
    );

    modport slave (
        output in_byte, in_byte_valid, out_byte_ready,
        input  out_byte, out_byte_valid, line_len, line_done, overflow_err, overrun_err, busy
    );

endinterface

// File: rtl/rx_line_buffer.sv
// Line storage: synchronous write port and a registered, read-enabled read port whose
// output register doubles as the out_byte holding register.
module rx_line_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_line_ctrl,
    input  logic          rst_line_ctrl,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_line_ctrl) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_line_ctrl) begin
        if (rst_line_ctrl) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rx_line_controller.sv
// Frames the UART RX byte stream into lines (CR/LF are framing only) and drains each
// completed line to the command parser over a valid/ready handshake.
module rx_line_controller
    import rx_uart_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int LEN_W = 6
) (
    input  logic                 clk_line_ctrl,
    input  logic                 rst_line_ctrl,
    rx_line_controller_if.master lc,
    output line_state_e          state_dbg
);

    localparam int AW = $clog2(DEPTH);

    line_state_e      state_q, state_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             ovr_q, ovr_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             mem_re;
    logic [AW-1:0]    mem_raddr;

    logic is_cr, is_lf, full, xfer, last_xfer;

    assign is_cr     = (lc.in_byte == CHAR_CR);
    assign is_lf     = (lc.in_byte == CHAR_LF);
    assign full      = (wr_cnt_q == LEN_W'(DEPTH));
    assign xfer      = out_valid_q & lc.out_byte_ready;
    assign last_xfer = (({{(LEN_W-AW){1'b0}}, rd_ptr_q} + LEN_W'(1)) == line_len_q);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        line_len_d  = line_len_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        ovf_d       = 1'b0;
        ovr_d       = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_cnt_q[AW-1:0];
        mem_re      = 1'b0;
        mem_raddr   = rd_ptr_q + AW'(1);

        case (state_q)
            COLLECT, CR_SEEN: begin
                if (lc.in_byte_valid) begin
                    if (is_lf) begin
                        if (wr_cnt_q != '0) begin
                            // Preload buf[0] so valid and the first byte appear together.
                            line_len_d  = wr_cnt_q;
                            rd_ptr_d    = '0;
                            mem_re      = 1'b1;
                            mem_raddr   = '0;
                            out_valid_d = 1'b1;
                            state_d     = DRAIN;
                        end else begin
                            state_d = COLLECT;
                        end
                    end else if (is_cr) begin
                        state_d = CR_SEEN;
                    end else if (full) begin
                        state_d = OVERFLOW;
                    end else begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + LEN_W'(1);
                        state_d  = COLLECT;
                    end
                end
            end
            DRAIN: begin
                ovr_d = lc.in_byte_valid;
                if (xfer) begin
                    if (last_xfer) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        wr_cnt_d    = '0;
                        state_d     = COLLECT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        mem_re   = 1'b1;
                    end
                end
            end
            OVERFLOW: begin
                if (lc.in_byte_valid && is_lf) begin
                    ovf_d    = 1'b1;
                    wr_cnt_d = '0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_line_ctrl) begin
        if (rst_line_ctrl) begin
            state_q     <= COLLECT;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            line_len_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            line_len_q  <= line_len_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            ovr_q       <= ovr_d;
        end
    end

    rx_line_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk_line_ctrl (clk_line_ctrl),
        .rst_line_ctrl (rst_line_ctrl),
        .we            (mem_we),
        .waddr         (mem_waddr),
        .wdata         (lc.in_byte),
        .re            (mem_re),
        .raddr         (mem_raddr),
        .rdata         (lc.out_byte)
    );

    assign lc.out_byte_valid = out_valid_q;
    assign lc.line_len       = line_len_q;
    assign lc.line_done      = done_q;
    assign lc.overflow_err   = ovf_q;
    assign lc.overrun_err    = ovr_q;
    assign lc.busy           = (state_q == DRAIN) || (state_q == OVERFLOW);
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_rx_line_controller.sv
// Directed bench for rx_line_controller: expected line bytes go into a queue when a line
// is sent, and a negedge monitor pops and compares on every accepted transfer.
module tb_rx_line_controller;
    import rx_uart_pkg::*;

    localparam int DEPTH = 32;
    localparam int LEN_W = 6;
    localparam int EW    = 1 + LEN_W + 8;  // {last, line_len, byte}

    logic clk;
    logic rst;
    line_state_e state_dbg;

    rx_line_controller_if #(.LEN_W(LEN_W)) bus ();

    rx_line_controller #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_line_ctrl (clk),
        .rst_line_ctrl (rst),
        .lc            (bus),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0, ovf_cnt = 0, ovr_cnt = 0;
    int d0 = 0, o0 = 0, r0 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    logic       pend_last = 1'b0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            pend_last = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (pend_last) begin
                check("line_done_after_last", int'(bus.line_done), 1);
                check("valid_low_after_last", int'(bus.out_byte_valid), 0);
                pend_last = 1'b0;
            end
            if (hold_pend) begin
                check("hold_valid", int'(bus.out_byte_valid), 1);
                check("hold_byte", int'(bus.out_byte), int'(hold_byte));
                hold_pend = 1'b0;
            end
            if (bus.line_done)    done_cnt++;
            if (bus.overflow_err) ovf_cnt++;
            if (bus.overrun_err)  ovr_cnt++;
            if (bus.out_byte_valid && bus.out_byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(bus.out_byte), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", int'(bus.out_byte), int'(e[7:0]));
                    check("line_len", int'(bus.line_len), int'(e[LEN_W+7:8]));
                    pend_last = e[EW-1];
                end
            end else if (bus.out_byte_valid) begin
                hold_pend = 1'b1;
                hold_byte = bus.out_byte;
            end
        end
    end

    // driver tasks (called at posedge + #1)
    task automatic send_byte(input logic [7:0] b);
        bus.in_byte       = b;
        bus.in_byte_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b, input int len, input logic last);
        exp_q.push_back({last, LEN_W'(len), b});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.out_byte_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", int'(n < budget), 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic begin_scn();
        d0 = done_cnt; o0 = ovf_cnt; r0 = ovr_cnt;
    endtask

    task automatic end_scn(input string name, input int ed, input int eo, input int er);
        check({name, "_line_done"}, done_cnt - d0, ed);
        check({name, "_overflow"}, ovf_cnt - o0, eo);
        check({name, "_overrun"}, ovr_cnt - r0, er);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_byte = 8'h00;
        bus.in_byte_valid = 1'b0;
        bus.out_byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_byte", int'(bus.out_byte), 0);
        check("rst_valid", int'(bus.out_byte_valid), 0);
        check("rst_line_len", int'(bus.line_len), 0);
        check("rst_pulses", int'({bus.line_done, bus.overflow_err, bus.overrun_err, bus.busy}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // "AB\r\n", ready held high
        begin_scn();
        bus.out_byte_ready = 1'b1;
        expect_byte(8'h41, 2, 1'b0);
        expect_byte(8'h42, 2, 1'b1);
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D); send_byte(8'h0A);
        wait_idle(50);
        end_scn("ab_crlf", 1, 0, 0);

        // "HI\n" with ready low for 5 cycles
        begin_scn();
        bus.out_byte_ready = 1'b0;
        expect_byte(8'h48, 2, 1'b0);
        expect_byte(8'h49, 2, 1'b1);
        send_byte(8'h48); send_byte(8'h49); send_byte(8'h0A);
        idle(5);
        @(negedge clk);
        check("stall_valid", int'(bus.out_byte_valid), 1);
        check("stall_byte", int'(bus.out_byte), 8'h48);
        @(posedge clk); #1;
        bus.out_byte_ready = 1'b1;
        wait_idle(50);
        end_scn("hi_stall", 1, 0, 0);

        // empty lines
        begin_scn();
        send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h0A);
        idle(4);
        check("empty_valid", int'(bus.out_byte_valid), 0);
        end_scn("empty", 0, 0, 0);

        // exactly DEPTH bytes fills the buffer without overflow
        begin_scn();
        for (int i = 0; i < DEPTH; i++) begin
            expect_byte(8'h60 + 8'(i), DEPTH, i == DEPTH - 1);
        end
        for (int i = 0; i < DEPTH; i++) send_byte(8'h60 + 8'(i));
        send_byte(8'h0A);
        wait_idle(100);
        end_scn("full_line", 1, 0, 0);

        // DEPTH+1 bytes overflow, then "X\n"
        begin_scn();
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h55);
        send_byte(8'h0A);
        idle(3);
        check("ovf_no_valid", int'(bus.out_byte_valid), 0);
        end_scn("overflow", 0, 1, 0);
        begin_scn();
        expect_byte(8'h58, 1, 1'b1);
        send_byte(8'h58); send_byte(8'h0A);
        wait_idle(50);
        end_scn("after_ovf", 1, 0, 0);

        // overrun during a stalled drain of "ABCD" (data byte and LF both dropped)
        begin_scn();
        bus.out_byte_ready = 1'b0;
        expect_byte(8'h41, 4, 1'b0);
        expect_byte(8'h42, 4, 1'b0);
        expect_byte(8'h43, 4, 1'b0);
        expect_byte(8'h44, 4, 1'b1);
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44); send_byte(8'h0A);
        idle(2);
        send_byte(8'h5A);
        idle(1);
        send_byte(8'h0A);
        idle(2);
        bus.out_byte_ready = 1'b1;
        wait_idle(50);
        end_scn("overrun", 1, 0, 2);

        // byte strobed in the line_done cycle is kept
        begin_scn();
        expect_byte(8'h51, 1, 1'b1);
        expect_byte(8'h52, 1, 1'b1);
        send_byte(8'h51); send_byte(8'h0A);
        idle(1);
        send_byte(8'h52); send_byte(8'h0A);
        wait_idle(50);
        end_scn("done_cycle_byte", 2, 0, 0);

        // "A\rB\n": bare CR dropped
        begin_scn();
        expect_byte(8'h41, 2, 1'b0);
        expect_byte(8'h42, 2, 1'b1);
        send_byte(8'h41); send_byte(8'h0D); send_byte(8'h42); send_byte(8'h0A);
        wait_idle(50);
        end_scn("bare_cr", 1, 0, 0);

        // reset mid-drain, then "Z\n"
        begin_scn();
        bus.out_byte_ready = 1'b0;
        expect_byte(8'h50, 2, 1'b0);
        expect_byte(8'h51, 2, 1'b1);
        send_byte(8'h50); send_byte(8'h51); send_byte(8'h0A);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", int'(bus.out_byte_valid), 0);
        check("mid_rst_out_byte", int'(bus.out_byte), 0);
        check("mid_rst_line_len", int'(bus.line_len), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_byte_ready = 1'b1;
        idle(1);
        expect_byte(8'h5A, 1, 1'b1);
        send_byte(8'h5A); send_byte(8'h0A);
        wait_idle(50);
        end_scn("reset_mid_drain", 1, 0, 0);

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
